fetch_ctrl: RTL
===============

# fetch_ctrl

Instruction-fetch sequencer between the program counter register and the instruction bus. It issues one bus read per PC value and stalls the PC while a read is outstanding or the decode stage is stalled. It holds taken-branch requests until the PC can accept them and discards in-flight reads killed by an exception flush. It also owns the IF/ID instruction register (`if_pc`, `if_inst`, `if_valid`).

## Interface
- No parameters; address and data widths fixed at 32.
- `clk` in 1: system clock, all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pc` in 32: current PC value.
- `inst_en` in 1: PC valid; low for the first cycle after reset.
- `stall_ext` in 1: downstream (ID and later) stall request.
- `flush` in 1: exception flush. The PC loads its flush target this cycle regardless of stall.
- `br_flag_i` in 1: taken branch or jump from ID, single-cycle pulse.
- `br_addr_i` in 32: branch target, valid with `br_flag_i`.
- `pc_stall` out 1: stall to PC.
- `pc_br_flag` out 1: branch request to PC.
- `pc_br_addr` out 32: branch target to PC.
- `ibus_req` out 1: instruction read request.
- `ibus_addr` out 32: read address.
- `ibus_ack` in 1: read complete; `ibus_rdata` valid this cycle. May arrive in the same cycle `ibus_req` first rises.
- `ibus_rdata` in 32: read data.
- `if_pc` out 32: IF/ID PC.
- `if_inst` out 32: IF/ID instruction.
- `if_valid` out 1: IF/ID contents valid.

## Operation
- States: IDLE, FETCH, HOLD, DROP. Internal registers:
  - `addr_q` (32): address of the outstanding read.
  - `buf_q` (32): instruction parked during HOLD.
  - `br_pend` (1) and `br_tgt` (32): deferred branch.
- IDLE:
  - Outputs: `ibus_req`=0, `pc_stall`=0.
  - `inst_en`=1 → FETCH.
- FETCH:
  - `ibus_req`=1, `ibus_addr`=`pc`, `addr_q`<=`pc` each cycle.
  - `pc_stall` = !(`ibus_ack` & !`stall_ext`).
  - `ibus_ack` & !`stall_ext`: `if_pc`<=`pc`, `if_inst`<=`ibus_rdata`, `if_valid`<=1; stay in FETCH.
  - `ibus_ack` & `stall_ext`: `buf_q`<=`ibus_rdata` → HOLD. `if_*` hold.
  - No ack & !`stall_ext`: `if_valid`<=0 (bubble). No ack & `stall_ext`: `if_*` hold.
- HOLD:
  - `ibus_req`=0, `pc_stall`=`stall_ext`.
  - When `stall_ext`=0: `if_pc`<=`pc`, `if_inst`<=`buf_q`, `if_valid`<=1 → FETCH.
- DROP (a flushed read is still outstanding on the bus):
  - `ibus_req`=1, `ibus_addr`=`addr_q`, `pc_stall`=1.
  - `ibus_ack` → discard data, go to FETCH.
- Flush (priority over everything):
  - `if_valid`<=0 and `br_pend`<=0.
  - FETCH without ack → DROP.
  - FETCH with ack → FETCH, data discarded.
  - HOLD → FETCH, `buf_q` discarded.
  - DROP → DROP (read still outstanding).
  - IDLE → IDLE.
- Branch hold-off:
  - `pc_br_flag` = `br_pend` | `br_flag_i`.
  - `pc_br_addr` = `br_pend` ? `br_tgt` : `br_addr_i`.
  - Consumed when `pc_stall`=0 and `flush`=0: `br_pend`<=0.
  - `br_flag_i` arriving while `pc_stall`=1: `br_pend`<=1, `br_tgt`<=`br_addr_i`.
  - While `br_pend`=1, further `br_flag_i` pulses are ignored.
  - The PC holds the delay-slot address when a branch is in ID. The branch is applied on the cycle the delay-slot fetch completes, so the delay slot is always fetched.
- Each bus transaction completes exactly once. `ibus_addr` never changes while `ibus_req`=1 and no ack has been seen. In FETCH this holds because `pc_stall` keeps `pc` constant, and `flush` diverts to DROP.

## Timing
- Reset values:
  - state IDLE.
  - `if_valid`=0, `if_pc`=0, `if_inst`=0.
  - `br_pend`=0, `br_tgt`=0, `addr_q`=0, `buf_q`=0.
  - Combinational outputs follow state: `ibus_req`=0, `pc_stall`=0, `pc_br_flag`=`br_flag_i`.
- Reset mid-transaction: state returns to IDLE immediately. The outstanding read is abandoned; the bus is reset with the core.
- Zero-wait bus (ack in the cycle of request): one instruction per cycle, `pc_stall` never asserted.
- N wait cycles: `pc_stall` high for N cycles, then the fetch completes. `if_*` updates at the edge ending the ack cycle.
- HOLD exit to the first new request: 1 cycle.
- Simultaneous `flush` and `ibus_ack` in FETCH: data discarded, no DROP.

## Test plan
- Zero-wait: reset, `inst_en` rises, ack every cycle with rdata=addr^0xFFFF_FFFF → `if_pc` steps 0xBFC0_0000, +4, +8…, `if_valid`=1 continuously, `pc_stall`=0.
- Wait states: ack 2 cycles after req at 0xBFC0_0004 → `pc_stall`=1 for 2 cycles, one `if_valid` bubble, `ibus_addr` stable.
- Downstream stall: `stall_ext`=1 for 3 cycles, with ack in the first of them → HOLD entered, `ibus_req`=0. When stall drops, `if_inst`=`buf_q` and `pc` advances by exactly 4.
- Flush mid-read: req at 0x8000_0100 with no ack, `flush`=1 → DROP, `ibus_addr`=0x8000_0100 until ack. Data discarded, `if_valid`=0, next request at the flush target.
- Deferred branch: `br_flag_i`=1 with target 0x8000_2000 during a wait state → `br_pend`=1. The PC loads 0x8000_2000 only after the delay-slot ack; the delay-slot instruction appears with `if_valid`=1.
- Flush clears pending branch: `br_pend`=1 then `flush`=1 → `pc_br_flag`=0 next cycle, the PC takes the flush target, and the branch target is never requested.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues one bus read per PC value, parks data across
// downstream stalls, defers taken branches and drains reads killed by a flush.
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        inst_en,
    input  logic        stall_ext,
    input  logic        flush,
    input  logic        br_flag_i,
    input  logic [31:0] br_addr_i,
    output logic        pc_stall,
    output logic        pc_br_flag,
    output logic [31:0] pc_br_addr,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] addr_r;
    logic [31:0] buf_r;
    logic        br_pend_r;
    logic [31:0] br_tgt_r;

    // Bus request, PC stall and branch forwarding decoded from the current state.
    always_comb begin
        ibus_req  = 1'b0;
        ibus_addr = pc;
        pc_stall  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ibus_req = 1'b0;
                pc_stall = 1'b0;
            end
            ST_FETCH: begin
                ibus_req  = 1'b1;
                ibus_addr = pc;
                pc_stall  = ~(ibus_ack & ~stall_ext);
            end
            ST_HOLD: begin
                ibus_req = 1'b0;
                pc_stall = stall_ext;
            end
            ST_DROP: begin
                ibus_req  = 1'b1;
                ibus_addr = addr_r;
                pc_stall  = 1'b1;
            end
            default: begin
                ibus_req = 1'b0;
                pc_stall = 1'b0;
            end
        endcase
        pc_br_flag = br_pend_r | br_flag_i;
        pc_br_addr = br_pend_r ? br_tgt_r : br_addr_i;
    end

    // Deferred branch: captured while the PC is stalled, released once it can move.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_pend_r <= 1'b0;
            br_tgt_r  <= 32'd0;
        end else if (flush) begin
            br_pend_r <= 1'b0;
        end else if (!pc_stall) begin
            br_pend_r <= 1'b0;
        end else if (br_flag_i && !br_pend_r) begin
            br_pend_r <= 1'b1;
            br_tgt_r  <= br_addr_i;
        end
    end

    // Fetch sequencer and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            addr_r   <= 32'd0;
            buf_r    <= 32'd0;
            if_pc    <= 32'd0;
            if_inst  <= 32'd0;
            if_valid <= 1'b0;
        end else if (flush) begin
            if_valid <= 1'b0;
            case (state_r)
                ST_IDLE:  state_r <= ST_IDLE;
                ST_FETCH: begin
                    addr_r  <= pc;
                    // An unacknowledged read must still be drained before refetching.
                    state_r <= ibus_ack ? ST_FETCH : ST_DROP;
                end
                ST_HOLD:  state_r <= ST_FETCH;
                ST_DROP:  state_r <= ST_DROP;
                default:  state_r <= ST_IDLE;
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (inst_en) begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    addr_r <= pc;
                    if (ibus_ack && !stall_ext) begin
                        if_pc    <= pc;
                        if_inst  <= ibus_rdata;
                        if_valid <= 1'b1;
                    end else if (ibus_ack) begin
                        buf_r   <= ibus_rdata;
                        state_r <= ST_HOLD;
                    end else if (!stall_ext) begin
                        if_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!stall_ext) begin
                        if_pc    <= pc;
                        if_inst  <= buf_r;
                        if_valid <= 1'b1;
                        state_r  <= ST_FETCH;
                    end
                end
                ST_DROP: begin
                    if (ibus_ack) begin
                        state_r <= ST_FETCH;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule
